// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset vector and fetch-state encoding for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 18;

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one program-memory read at a time, buffers the
// returned word for decode, and handles redirects, including redirects that land
// while a request is still outstanding (the stale response is drained and dropped).
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [PC_W-1:0]    o_imemAddr,
  output logic               o_imemReq,
  input  logic               i_imemAck,
  input  logic [INSTR_W-1:0] i_imemData,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instrValid,
  output logic [PC_W-1:0]    o_instrPc,
  input  logic               i_decodeReady,
  input  logic               i_jumpTaken,
  input  logic [PC_W-1:0]    i_jumpTarget
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_addr_q, req_addr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_buf_q, instr_buf_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    pc_inc;

  // Sequential successor of the address just fetched; wraps naturally at 16 bits.
  always_comb pc_inc = req_addr_q + PC_W'(1);

  // Next-state and register update logic; jumps always win over sequential flow.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    instr_pc_d  = instr_pc_q;
    instr_buf_d = instr_buf_q;
    valid_d     = valid_q;

    unique case (state_q)
      START: begin
        req_addr_d = pc_q;
        state_d    = FETCH;
      end
      FETCH: begin
        if (i_imemAck) begin
          if (i_jumpTaken) begin
            pc_d       = i_jumpTarget;
            req_addr_d = i_jumpTarget;
          end else begin
            instr_buf_d = i_imemData;
            instr_pc_d  = req_addr_q;
            valid_d     = 1'b1;
            pc_d        = pc_inc;
            state_d     = HOLD;
          end
        end else if (i_jumpTaken) begin
          // Request must stay stable until acked, so remember the target and drain.
          pc_d    = i_jumpTarget;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_jumpTaken) begin
          pc_d = i_jumpTarget;
        end
        if (i_imemAck) begin
          req_addr_d = pc_d;
          state_d    = FETCH;
        end
      end
      HOLD: begin
        if (i_jumpTaken) begin
          valid_d    = 1'b0;
          pc_d       = i_jumpTarget;
          req_addr_d = i_jumpTarget;
          state_d    = FETCH;
        end else if (valid_q && i_decodeReady) begin
          valid_d    = 1'b0;
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = START;
    endcase

    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= START;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      instr_pc_q  <= RESET_PC;
      instr_buf_q <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      instr_pc_q  <= instr_pc_d;
      instr_buf_q <= instr_buf_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
    end
  end

  assign o_imemAddr    = req_addr_q;
  assign o_imemReq     = req_q;
  assign o_instruction = instr_buf_q;
  assign o_instrValid  = valid_q;
  assign o_instrPc     = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: sequential table run plus redirect,
// stall, wrap and reset corner sequences, with a scoreboard of issued words.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [PC_W-1:0]    o_imemAddr;
  logic               o_imemReq;
  logic               i_imemAck;
  logic [INSTR_W-1:0] i_imemData;
  logic [INSTR_W-1:0] o_instruction;
  logic               o_instrValid;
  logic [PC_W-1:0]    o_instrPc;
  logic               i_decodeReady;
  logic               i_jumpTaken;
  logic [PC_W-1:0]    i_jumpTarget;

  instr_fetch dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imemAddr    (o_imemAddr),
    .o_imemReq     (o_imemReq),
    .i_imemAck     (i_imemAck),
    .i_imemData    (i_imemData),
    .o_instruction (o_instruction),
    .o_instrValid  (o_instrValid),
    .o_instrPc     (o_instrPc),
    .i_decodeReady (i_decodeReady),
    .i_jumpTaken   (i_jumpTaken),
    .i_jumpTarget  (i_jumpTarget)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  typedef struct {
    logic [PC_W-1:0]    addr;
    logic [INSTR_W-1:0] data;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Compare the presented instruction against the oldest scoreboard entry.
  task automatic check_out(input string name);
    exp_t e;
    check({name, "_valid"}, 32'(o_instrValid), 32'd1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_instr"}, 32'(o_instruction), 32'(e.instr));
      check({name, "_pc"}, 32'(o_instrPc), 32'(e.pc));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst         = 1'b1;
    i_imemAck     = 1'b0;
    i_imemData    = '0;
    i_decodeReady = 1'b0;
    i_jumpTaken   = 1'b0;
    i_jumpTarget  = '0;

    tbl[0] = '{16'h0000, 18'h11111};
    tbl[1] = '{16'h0001, 18'h22222};
    tbl[2] = '{16'h0002, 18'h33333};
    tbl[3] = '{16'h0003, 18'h3C0DE};
    tbl[4] = '{16'h0004, 18'h00404};

    // Reset state
    do_reset();
    check("rst_req", 32'(o_imemReq), 32'd0);
    check("rst_valid", 32'(o_instrValid), 32'd0);
    check("rst_addr", 32'(o_imemAddr), 32'd0);
    check("rst_instr", 32'(o_instruction), 32'd0);
    check("rst_pc", 32'(o_instrPc), 32'd0);

    // First request one cycle after release, acked with 0ABCD
    tick();
    check("first_req", 32'(o_imemReq), 32'd1);
    check("first_addr", 32'(o_imemAddr), 32'd0);
    i_imemAck  = 1'b1;
    i_imemData = 18'h0ABCD;
    sb_q.push_back('{16'h0000, 18'h0ABCD});
    tick();
    i_imemAck = 1'b0;
    check_out("first");
    check("first_hold_req", 32'(o_imemReq), 32'd0);
    i_decodeReady = 1'b1;
    tick();
    i_decodeReady = 1'b0;
    check("first_next_req", 32'(o_imemReq), 32'd1);
    check("first_next_addr", 32'(o_imemAddr), 32'd1);

    // Sequential zero-wait stream, one instruction every two cycles
    do_reset();
    tick();
    i_decodeReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("seq%0d_req", i), 32'(o_imemReq), 32'd1);
      check($sformatf("seq%0d_addr", i), 32'(o_imemAddr), 32'(tbl[i].addr));
      i_imemAck  = 1'b1;
      i_imemData = tbl[i].data;
      sb_q.push_back('{tbl[i].addr, tbl[i].data});
      tick();
      i_imemAck = 1'b0;
      check_out($sformatf("seq%0d", i));
      tick();
    end
    i_decodeReady = 1'b0;

    // Jump to 0x0040 during a waited request at 0x0005
    check("drain_start_addr", 32'(o_imemAddr), 32'h5);
    i_jumpTaken  = 1'b1;
    i_jumpTarget = 16'h0040;
    tick();
    i_jumpTaken = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("drain_w%0d_req", w), 32'(o_imemReq), 32'd1);
      check($sformatf("drain_w%0d_addr", w), 32'(o_imemAddr), 32'h5);
      if (w < 2) tick();
    end
    i_imemAck  = 1'b1;
    i_imemData = 18'h2DEAD;
    tick();
    i_imemAck = 1'b0;
    check("drain_drop_valid", 32'(o_instrValid), 32'd0);
    check("drain_next_req", 32'(o_imemReq), 32'd1);
    check("drain_next_addr", 32'(o_imemAddr), 32'h40);

    // Stall in HOLD, stray ack ignored, then jump to 0x0100
    i_imemAck  = 1'b1;
    i_imemData = 18'h04040;
    sb_q.push_back('{16'h0040, 18'h04040});
    tick();
    check_out("hold");
    i_imemData = 18'h3FFFF;
    for (int s = 0; s < 4; s++) begin
      tick();
      i_imemAck = 1'b0;
      check($sformatf("hold%0d_instr", s), 32'(o_instruction), 32'h04040);
      check($sformatf("hold%0d_valid", s), 32'(o_instrValid), 32'd1);
      check($sformatf("hold%0d_req", s), 32'(o_imemReq), 32'd0);
    end
    i_jumpTaken  = 1'b1;
    i_jumpTarget = 16'h0100;
    tick();
    i_jumpTaken = 1'b0;
    check("hold_jump_valid", 32'(o_instrValid), 32'd0);
    check("hold_jump_req", 32'(o_imemReq), 32'd1);
    check("hold_jump_addr", 32'(o_imemAddr), 32'h100);

    // Jump coinciding with ack to 0xFFFF, then wrap to 0x0000
    i_imemAck    = 1'b1;
    i_imemData   = 18'h01010;
    i_jumpTaken  = 1'b1;
    i_jumpTarget = 16'hFFFF;
    tick();
    i_jumpTaken = 1'b0;
    check("ackjump_valid", 32'(o_instrValid), 32'd0);
    check("ackjump_addr", 32'(o_imemAddr), 32'hFFFF);
    i_imemData = 18'h1FFFF;
    sb_q.push_back('{16'hFFFF, 18'h1FFFF});
    tick();
    i_imemAck = 1'b0;
    check_out("wrap");
    i_decodeReady = 1'b1;
    tick();
    i_decodeReady = 1'b0;
    check("wrap_req", 32'(o_imemReq), 32'd1);
    check("wrap_addr", 32'(o_imemAddr), 32'h0);

    // Two jumps while draining: the last one wins
    i_jumpTaken  = 1'b1;
    i_jumpTarget = 16'h0030;
    tick();
    i_jumpTarget = 16'h0050;
    tick();
    i_jumpTaken = 1'b0;
    check("lastjump_hold_addr", 32'(o_imemAddr), 32'h0);
    i_imemAck = 1'b1;
    tick();
    i_imemAck = 1'b0;
    check("lastjump_valid", 32'(o_instrValid), 32'd0);
    check("lastjump_addr", 32'(o_imemAddr), 32'h50);

    // Reset during an outstanding request at 0x0020
    i_imemAck    = 1'b1;
    i_jumpTaken  = 1'b1;
    i_jumpTarget = 16'h0020;
    tick();
    i_imemAck = 1'b0;
    check("rstmid_addr", 32'(o_imemAddr), 32'h20);
    check("rstmid_req", 32'(o_imemReq), 32'd1);
    i_rst = 1'b1;
    tick();
    i_jumpTaken = 1'b0;
    check("rstmid_req_off", 32'(o_imemReq), 32'd0);
    check("rstmid_valid", 32'(o_instrValid), 32'd0);
    check("rstmid_addr0", 32'(o_imemAddr), 32'h0);
    i_rst = 1'b0;
    tick();
    check("rstmid_first_req", 32'(o_imemReq), 32'd1);
    check("rstmid_first_addr", 32'(o_imemAddr), 32'h0);

    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
